// File: rtl/ac_gr_pkg.sv
// ac_gr_pkg: shared types, thresholds and k helper for the AC-level Golomb-Rice scheduler
package ac_gr_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int K_T1      = 2;
    localparam int K_T2      = 4;
    localparam int K_MAX_DEF = 2;
    typedef struct packed {
        logic [31:0] code;
        logic [5:0]  len;
        logic        last;
    } fifo_entry_t;
    function automatic logic [2:0] k_from_prev(input logic [31:0] prev_abs, input logic [2:0] k_max);
        logic [2:0] k;
        k = (prev_abs >= 32'(K_T2)) ? 3'd2 : (prev_abs >= 32'(K_T1)) ? 3'd1 : 3'd0;
        return (k > k_max) ? k_max : k;
    endfunction
endpackage

// File: rtl/ac_gr_out_fifo.sv
// ac_gr_out_fifo: register-based sync FIFO with simultaneous push/pop and occupancy count
module ac_gr_out_fifo
    import ac_gr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  fifo_entry_t              i_din,
    input  logic                     i_pop,
    output fifo_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    fifo_entry_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [AW:0]     r_cnt;
    // storage and pointers; the caller never pushes into a full FIFO or pops an empty one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_mem[r_wr] <= i_din;
            r_wr  <= r_wr + AW'(i_push);
            r_rd  <= r_rd + AW'(i_pop);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/ac_level_gr_scheduler.sv
// ac_level_gr_scheduler: issues signed AC levels to a Golomb-Rice unit with adaptive k and buffers codewords
module ac_level_gr_scheduler
    import ac_gr_pkg::*;
#(
    parameter int LVL_W      = 16,
    parameter int K_MAX      = K_MAX_DEF,
    parameter int GR_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_COEF   = 63
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [LVL_W-1:0] s_level,
    input  logic             s_last,
    output logic [2:0]       gr_k,
    output logic [31:0]      gr_val,
    output logic             gr_is_ac,
    output logic             gr_is_minus_n,
    input  logic [31:0]      gr_sum_n,
    input  logic [31:0]      gr_cw_len,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_code,
    output logic [5:0]       m_len,
    output logic             m_last,
    output logic             blk_done,
    output logic             err
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(MAX_COEF + 2);
    state_t            r_state, w_state_nxt;
    logic              r_s_ready, r_err, r_blk_done, r_iss_v, r_iss_l;
    logic [LVL_W:0]    r_prev_abs, w_sx, w_abs, w_val;
    logic [CW-1:0]     r_coef;
    logic [FW-1:0]     r_inflight, w_inflight_nxt, w_cnt, w_cnt_nxt;
    logic [GR_LAT-1:0] r_pipe_v, r_pipe_l;
    logic              w_acc, w_zero, w_iss, w_force, w_last, w_push, w_pop, w_len_ovf, w_ready_nxt;
    logic [2:0]        w_k;
    fifo_entry_t       w_entry, w_head;
    // accept/issue decode, magnitude with one extra bit so the most negative level fits, next-state and credit
    always_comb begin
        w_acc          = s_valid && r_s_ready;
        w_zero         = s_level == '0;
        w_iss          = w_acc && !w_zero;
        w_force        = w_iss && !s_last && r_coef == CW'(MAX_COEF);
        w_last         = w_iss && (s_last || w_force);
        w_sx           = {s_level[LVL_W-1], s_level};
        w_abs          = w_sx[LVL_W] ? ~w_sx + (LVL_W+1)'(1) : w_sx;
        w_val          = w_abs - (LVL_W+1)'(1);
        w_k            = k_from_prev(32'(r_prev_abs), 3'(K_MAX));
        w_push         = r_pipe_v[GR_LAT-1];
        w_pop          = m_valid && m_ready;
        w_len_ovf      = gr_cw_len > 32'd63;
        w_entry        = '{code: gr_sum_n, len: w_len_ovf ? 6'd63 : gr_cw_len[5:0], last: r_pipe_l[GR_LAT-1]};
        w_inflight_nxt = r_inflight + FW'(w_iss) - FW'(w_push);
        w_cnt_nxt      = w_cnt + FW'(w_push) - FW'(w_pop);
        w_state_nxt    = (r_state == DRAIN) ? ((w_pop && w_head.last && r_inflight == '0) ? IDLE : DRAIN)
                       : w_last ? DRAIN : w_iss ? RUN : r_state;
        w_ready_nxt    = (w_state_nxt != DRAIN) &&
                         ({1'b0, w_cnt_nxt} + {1'b0, w_inflight_nxt} < (FW+1)'(FIFO_DEPTH));
    end
    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    // block bookkeeping: credit-based ready, k history, coefficient count, sticky error, done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_ready  <= 1'b0;
            r_prev_abs <= (LVL_W+1)'(1);
            r_coef     <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
            r_blk_done <= 1'b0;
        end else begin
            r_s_ready  <= w_ready_nxt;
            r_prev_abs <= w_last ? (LVL_W+1)'(1) : w_iss ? w_abs : r_prev_abs;
            r_coef     <= w_last ? '0 : w_iss ? r_coef + CW'(1) : r_coef;
            r_inflight <= w_inflight_nxt;
            r_err      <= r_err || (w_acc && w_zero) || w_force || (w_push && w_len_ovf);
            r_blk_done <= w_pop && w_head.last;
        end
    end
    // issue register toward the GR unit; idle cycles present val=0 with an empty tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gr_k          <= 3'd0;
            gr_val        <= 32'd0;
            gr_is_minus_n <= 1'b0;
            r_iss_v       <= 1'b0;
            r_iss_l       <= 1'b0;
        end else begin
            gr_k          <= w_iss ? w_k : 3'd0;
            gr_val        <= w_iss ? 32'(w_val) : 32'd0;
            gr_is_minus_n <= w_iss && w_sx[LVL_W];
            r_iss_v       <= w_iss;
            r_iss_l       <= w_last;
        end
    end
    // tag pipe tracking which GR result cycles belong to issued levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_v <= '0;
            r_pipe_l <= '0;
        end else begin
            r_pipe_v <= GR_LAT'({r_pipe_v, r_iss_v});
            r_pipe_l <= GR_LAT'({r_pipe_l, r_iss_l});
        end
    end
    ac_gr_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_cnt)
    );
    assign s_ready  = r_s_ready;
    assign gr_is_ac = 1'b1;
    assign m_valid  = w_cnt != '0;
    assign m_code   = w_head.code;
    assign m_len    = w_head.len;
    assign m_last   = w_head.last;
    assign blk_done = r_blk_done;
    assign err      = r_err;
endmodule

// File: tb/tb_ac_level_gr_scheduler.sv
// tb_ac_level_gr_scheduler: randomized and directed bench against a queue-based reference model
module tb_ac_level_gr_scheduler;
    localparam int GR_LAT = 2;
    localparam int K_MAX  = 2;
    localparam int TMO    = 400;
    typedef struct {
        logic [31:0] code;
        logic [5:0]  len;
        logic        last;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last, blk_done, err;
    logic [15:0] s_level;
    logic [2:0]  gr_k;
    logic [31:0] gr_val, gr_sum_n, gr_cw_len, m_code;
    logic        gr_is_ac, gr_is_minus_n;
    logic [5:0]  m_len;
    int          checks = 0, errors = 0, rdy_mode = 0;
    int          m_prev = 1, m_coef = 0;
    bit          exp_err = 0, pend = 0, pend_zero = 0, exp_bd = 0;
    logic [2:0]  pend_k;
    logic [31:0] pend_val;
    logic        pend_neg;
    exp_t        expq[$];
    exp_t        e;
    logic [31:0] gp_code [GR_LAT];
    logic [31:0] gp_len  [GR_LAT];
    int          stall_lv [8] = '{3, -7, 1, 12, -2, 5, -9, 4};
    int          idx;
    logic        acc;

    ac_level_gr_scheduler dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_level(s_level),
        .s_last(s_last), .gr_k(gr_k), .gr_val(gr_val), .gr_is_ac(gr_is_ac),
        .gr_is_minus_n(gr_is_minus_n), .gr_sum_n(gr_sum_n), .gr_cw_len(gr_cw_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code), .m_len(m_len), .m_last(m_last),
        .blk_done(blk_done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gr_code(input logic [31:0] v, input logic [2:0] k, input logic neg);
        logic [63:0] q, c;
        q = 64'(v >> k);
        c = (((64'd1 << q) - 64'd1) << (32'(k) + 2)) | (64'(v & ((32'd1 << k) - 32'd1)) << 1) | 64'(neg);
        return c[31:0];
    endfunction

    function automatic logic [31:0] gr_len(input logic [31:0] v, input logic [2:0] k);
        return (v >> k) + 32'(k) + 32'd2;
    endfunction

    // external GR unit model with fixed latency
    always @(posedge clk) begin
        gp_code[0] <= gr_code(gr_val, gr_k, gr_is_minus_n);
        gp_len[0]  <= gr_len(gr_val, gr_k);
        for (int i = 1; i < GR_LAT; i++) begin
            gp_code[i] <= gp_code[i-1];
            gp_len[i]  <= gp_len[i-1];
        end
    end
    assign gr_sum_n  = gp_code[GR_LAT-1];
    assign gr_cw_len = gp_len[GR_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [15:0] lvl, input logic lst_in);
        int l, a, k, len;
        logic lst;
        exp_t x;
        l = int'($signed(lvl));
        if (l == 0) begin
            exp_err = 1;
            pend_zero = 1;
            return;
        end
        a = (l < 0) ? -l : l;
        k = (m_prev <= 1) ? 0 : (m_prev <= 3) ? 1 : 2;
        if (k > K_MAX) k = K_MAX;
        lst = lst_in || m_coef == 63;
        if (!lst_in && m_coef == 63) exp_err = 1;
        len = int'(gr_len(32'(a - 1), 3'(k)));
        if (len > 63) exp_err = 1;
        x.code = gr_code(32'(a - 1), 3'(k), l < 0);
        x.len  = (len > 63) ? 6'd63 : 6'(len);
        x.last = lst;
        expq.push_back(x);
        pend = 1;
        pend_k = 3'(k);
        pend_val = 32'(a - 1);
        pend_neg = l < 0;
        m_prev = lst ? 1 : a;
        m_coef = lst ? 0 : m_coef + 1;
    endtask

    // monitor: checks issue outputs, popped codewords and done pulse; feeds the model on accepts
    always @(negedge clk) begin
        if (reset_n) begin
            if (pend) begin
                chk("gr_k", gr_k, pend_k);
                chk("gr_val", gr_val, pend_val);
                chk("gr_neg", gr_is_minus_n, pend_neg);
            end else if (pend_zero) chk("zero_issue", gr_val, 0);
            chk("blk_done", blk_done, exp_bd);
            pend = 0;
            pend_zero = 0;
            exp_bd = 0;
            if (m_valid && m_ready) begin
                chk("pop_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("m_code", m_code, e.code);
                    chk("m_len", m_len, e.len);
                    chk("m_last", m_last, e.last);
                    exp_bd = e.last;
                end
            end else if (m_valid && expq.size() != 0) chk("hold_code", m_code, expq[0].code);
            if (s_valid && s_ready) model_accept(s_level, s_last);
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    task automatic clear_model();
        expq.delete();
        m_prev = 1;
        m_coef = 0;
        exp_err = 0;
        pend = 0;
        pend_zero = 0;
        exp_bd = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int lv, input logic lst);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_level = 16'(lv);
        s_last = lst;
        while (!s_ready && t < TMO) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("send_to", t < TMO, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || m_valid) && t < TMO) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_to", t < TMO, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        s_valid = 1'b0;
        s_level = '0;
        s_last = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_code", m_code, 0);
        chk("rst_m_len", m_len, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_blk_done", blk_done, 0);
        chk("rst_err", err, 0);
        chk("rst_gr_k", gr_k, 0);
        chk("rst_gr_val", gr_val, 0);
        chk("rst_gr_neg", gr_is_minus_n, 0);
        chk("gr_is_ac", gr_is_ac, 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // basic block: k sequence 0,0,1,1,2
        send(1, 0); send(-2, 0); send(3, 0); send(-5, 0); send(1, 1);
        wait_drain();
        chk("basic_err", err, 0);
        chk("basic_idle_ready", s_ready, 1);
        // downstream stall: exactly FIFO_DEPTH levels accepted, then release
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 20) begin
                chk("stall_acc", idx, 4);
                chk("stall_sready", s_ready, 0);
                rdy_mode = 0;
            end
            s_valid = idx < 8;
            s_level = (idx < 8) ? 16'(stall_lv[idx]) : 16'd0;
            s_last = idx == 7;
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        chk("stall_all", idx, 8);
        wait_drain();
        // back-to-back blocks: second block restarts at k=0
        send(-4, 0); send(2, 1); send(1, 1);
        wait_drain();
        // randomized blocks with random backpressure
        rdy_mode = 2;
        for (int b = 0; b < 8; b++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                int mag;
                mag = int'($urandom_range(1, 20));
                send($urandom_range(0, 1) != 0 ? -mag : mag, i == n - 1);
            end
        end
        rdy_mode = 0;
        wait_drain();
        chk("rand_err", err, exp_err);
        chk("rand_err_clear", err, 0);
        // reset with entries buffered and in flight
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(6, 0); send(-3, 0); send(2, 0); send(9, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 0);
        clear_model();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(3, 0); send(-1, 1);
        wait_drain();
        chk("postrst_err", err, 0);
        // zero level: dropped, error set, k history untouched
        send(5, 0); send(0, 0); send(-3, 1);
        wait_drain();
        chk("zero_err", err, 1);
        // 64 levels without s_last: last one forced
        do_reset();
        for (int i = 0; i < 64; i++) begin
            int mag;
            mag = int'($urandom_range(1, 20));
            send((i % 3 == 0) ? -mag : mag, 0);
        end
        chk("force_sready", s_ready, 0);
        wait_drain();
        chk("force_err", err, exp_err);
        chk("force_err_set", err, 1);
        chk("force_idle", s_ready, 1);
        send(2, 1);
        wait_drain();
        // most negative level: oversized codeword length saturates
        do_reset();
        send(-32768, 1);
        wait_drain();
        chk("len_err", err, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
